// File: rtl/bomberman_keyboard_input_if.sv
// PS/2 pins in, per-player game controls and scan-code status out.
interface bomberman_keyboard_input_if;
    logic       ps2_clk;
    logic       ps2_dat;
    logic       p1_xmov;
    logic       p1_xdir;
    logic       p1_ymov;
    logic       p1_ydir;
    logic       p2_xmov;
    logic       p2_xdir;
    logic       p2_ymov;
    logic       p2_ydir;
    logic       p1_bomb;
    logic       p2_bomb;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       frame_error;

    // Keyboard side: drives the raw pins, observes decoded controls.
    modport master (
        output ps2_clk, ps2_dat,
        input  p1_xmov, p1_xdir, p1_ymov, p1_ydir,
        input  p2_xmov, p2_xdir, p2_ymov, p2_ydir,
        input  p1_bomb, p2_bomb, scan_code, scan_valid, frame_error
    );

    // Decoder side.
    modport slave (
        input  ps2_clk, ps2_dat,
        output p1_xmov, p1_xdir, p1_ymov, p1_ydir,
        output p2_xmov, p2_xdir, p2_ymov, p2_ydir,
        output p1_bomb, p2_bomb, scan_code, scan_valid, frame_error
    );
endinterface

// File: rtl/bomberman_keyboard_input.sv
// PS/2 keyboard decoder: frames 11-bit packets, tracks make/break state of ten
// game keys and resolves them into registered movement levels and bomb pulses.
module bomberman_keyboard_input #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input logic                        clock,
    input logic                        reset,
    bomberman_keyboard_input_if.slave  kb
);

    localparam int unsigned WdogWidth = $clog2(TIMEOUT_CYCLES + 1);

    // Held-key bit positions.
    localparam logic [3:0] KeyP1Up    = 4'd0;
    localparam logic [3:0] KeyP1Down  = 4'd1;
    localparam logic [3:0] KeyP1Left  = 4'd2;
    localparam logic [3:0] KeyP1Right = 4'd3;
    localparam logic [3:0] KeyP1Bomb  = 4'd4;
    localparam logic [3:0] KeyP2Bomb  = 4'd5;
    localparam logic [3:0] KeyP2Up    = 4'd6;
    localparam logic [3:0] KeyP2Down  = 4'd7;
    localparam logic [3:0] KeyP2Left  = 4'd8;
    localparam logic [3:0] KeyP2Right = 4'd9;

    typedef enum logic [1:0] {StIdle, StRecv, StCheck} state_e;

    logic [2:0]           clk_sync_q;
    logic [1:0]           dat_sync_q;
    logic                 fall;
    logic                 dat_s;
    logic                 timeout;

    state_e               state_q;
    logic [3:0]           bit_cnt_q;
    logic [8:0]           shift_q;
    logic [WdogWidth-1:0] wdog_q;
    logic [7:0]           scan_code_q;
    logic                 scan_valid_q;
    logic                 frame_error_q;

    logic [9:0]           held_q, held_d;
    logic                 ext_q, ext_d;
    logic                 brk_q, brk_d;
    logic                 key_hit;
    logic [3:0]           key_idx;
    logic                 p1_bomb_d, p2_bomb_d;
    logic                 p1_bomb_q, p2_bomb_q;
    logic [3:0]           p1_mov_q, p2_mov_q;

    // Two-flop synchronisers; third ps2_clk flop provides the edge history.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_sync_q <= '0;
            dat_sync_q <= '0;
        end else begin
            clk_sync_q <= {clk_sync_q[1:0], kb.ps2_clk};
            dat_sync_q <= {dat_sync_q[0], kb.ps2_dat};
        end
    end

    assign fall    = clk_sync_q[2] & ~clk_sync_q[1];
    assign dat_s   = dat_sync_q[1];
    assign timeout = (state_q == StRecv) && !fall && (wdog_q >= WdogWidth'(TIMEOUT_CYCLES));

    // Frame receiver with watchdog; the stop bit is judged on the 11th edge so the
    // result pulses are registered and coincide with the CHECK cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            wdog_q        <= '0;
            scan_code_q   <= '0;
            scan_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            scan_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    wdog_q <= '0;
                    if (fall && !dat_s) begin
                        state_q   <= StRecv;
                        bit_cnt_q <= '0;
                    end
                end
                StRecv: begin
                    if (fall) begin
                        wdog_q <= '0;
                        if (bit_cnt_q == 4'd9) begin
                            // Odd parity over data+parity, stop bit must be high.
                            if ((^shift_q) && dat_s) begin
                                scan_code_q  <= shift_q[7:0];
                                scan_valid_q <= 1'b1;
                            end else begin
                                frame_error_q <= 1'b1;
                            end
                            state_q <= StCheck;
                        end else begin
                            shift_q   <= {dat_s, shift_q[8:1]};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end else if (timeout) begin
                        state_q <= StIdle;
                        wdog_q  <= '0;
                    end else begin
                        wdog_q <= wdog_q + WdogWidth'(1);
                    end
                end
                StCheck: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // Key map lookup and prefix/held-state next values for the byte in CHECK.
    always_comb begin
        held_d    = held_q;
        ext_d     = ext_q;
        brk_d     = brk_q;
        key_hit   = 1'b0;
        key_idx   = '0;
        p1_bomb_d = 1'b0;
        p2_bomb_d = 1'b0;
        case ({ext_q, scan_code_q})
            9'h01D: begin key_hit = 1'b1; key_idx = KeyP1Up;    end
            9'h01B: begin key_hit = 1'b1; key_idx = KeyP1Down;  end
            9'h01C: begin key_hit = 1'b1; key_idx = KeyP1Left;  end
            9'h023: begin key_hit = 1'b1; key_idx = KeyP1Right; end
            9'h029: begin key_hit = 1'b1; key_idx = KeyP1Bomb;  end
            9'h05A: begin key_hit = 1'b1; key_idx = KeyP2Bomb;  end
            9'h175: begin key_hit = 1'b1; key_idx = KeyP2Up;    end
            9'h172: begin key_hit = 1'b1; key_idx = KeyP2Down;  end
            9'h16B: begin key_hit = 1'b1; key_idx = KeyP2Left;  end
            9'h174: begin key_hit = 1'b1; key_idx = KeyP2Right; end
            default: ;
        endcase
        if (timeout || (state_q == StCheck && frame_error_q)) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (state_q == StCheck && scan_valid_q) begin
            if (scan_code_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (scan_code_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                if (key_hit) begin
                    held_d[key_idx] = ~brk_q;
                    // Only a fresh press fires; typematic repeats find the bit already set.
                    p1_bomb_d = !brk_q && !held_q[key_idx] && (key_idx == KeyP1Bomb);
                    p2_bomb_d = !brk_q && !held_q[key_idx] && (key_idx == KeyP2Bomb);
                end
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    // Key state and registered control outputs ({xmov, xdir, ymov, ydir}).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            held_q    <= '0;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            p1_bomb_q <= 1'b0;
            p2_bomb_q <= 1'b0;
            p1_mov_q  <= '0;
            p2_mov_q  <= '0;
        end else begin
            held_q    <= held_d;
            ext_q     <= ext_d;
            brk_q     <= brk_d;
            p1_bomb_q <= p1_bomb_d;
            p2_bomb_q <= p2_bomb_d;
            p1_mov_q  <= {held_d[KeyP1Left] ^ held_d[KeyP1Right],
                          held_d[KeyP1Right] & ~held_d[KeyP1Left],
                          held_d[KeyP1Up] ^ held_d[KeyP1Down],
                          held_d[KeyP1Down] & ~held_d[KeyP1Up]};
            p2_mov_q  <= {held_d[KeyP2Left] ^ held_d[KeyP2Right],
                          held_d[KeyP2Right] & ~held_d[KeyP2Left],
                          held_d[KeyP2Up] ^ held_d[KeyP2Down],
                          held_d[KeyP2Down] & ~held_d[KeyP2Up]};
        end
    end

    assign kb.p1_xmov     = p1_mov_q[3];
    assign kb.p1_xdir     = p1_mov_q[2];
    assign kb.p1_ymov     = p1_mov_q[1];
    assign kb.p1_ydir     = p1_mov_q[0];
    assign kb.p2_xmov     = p2_mov_q[3];
    assign kb.p2_xdir     = p2_mov_q[2];
    assign kb.p2_ymov     = p2_mov_q[1];
    assign kb.p2_ydir     = p2_mov_q[0];
    assign kb.p1_bomb     = p1_bomb_q;
    assign kb.p2_bomb     = p2_bomb_q;
    assign kb.scan_code   = scan_code_q;
    assign kb.scan_valid  = scan_valid_q;
    assign kb.frame_error = frame_error_q;

endmodule

// File: tb/tb_bomberman_keyboard_input.sv
// Randomised bench for bomberman_keyboard_input against a key-table model.
module tb_bomberman_keyboard_input;

    localparam int unsigned Timeout = 300;
    localparam int          H       = 6;   // half PS/2 bit time, in system clocks

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    bomberman_keyboard_input_if kb();

    bomberman_keyboard_input #(.TIMEOUT_CYCLES(Timeout)) dut (
        .clock (clock),
        .reset (reset),
        .kb    (kb)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pulse monitor.
    int cyc = 0;
    int sv_cyc = -100;
    int sv_cnt = 0, fe_cnt = 0, b1_cnt = 0, b2_cnt = 0;
    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) begin
        if (!reset) begin
            if (kb.scan_valid) begin
                sv_cnt++;
                sv_cyc = cyc;
            end
            if (kb.frame_error) fe_cnt++;
            if (kb.p1_bomb) begin
                b1_cnt++;
                check_eq("bomb1_latency", cyc - sv_cyc, 1);
            end
            if (kb.p2_bomb) begin
                b2_cnt++;
                check_eq("bomb2_latency", cyc - sv_cyc, 1);
            end
        end
    end

    // Reference model: named keys, pending prefixes, expected pulse counts.
    bit         m_held[string];
    bit         m_ext = 1'b0;
    bit         m_brk = 1'b0;
    int         exp_sv = 0, exp_fe = 0, exp_b1 = 0, exp_b2 = 0;
    logic [7:0] exp_code = 8'h00;

    function automatic bit held(input string n);
        return m_held.exists(n) ? m_held[n] : 1'b0;
    endfunction

    function automatic string key_name(input bit ext, input logic [7:0] c);
        if (!ext) begin
            case (c)
                8'h1D: return "p1u";
                8'h1B: return "p1d";
                8'h1C: return "p1l";
                8'h23: return "p1r";
                8'h29: return "p1b";
                8'h5A: return "p2b";
                default: return "";
            endcase
        end
        case (c)
            8'h75: return "p2u";
            8'h72: return "p2d";
            8'h6B: return "p2l";
            8'h74: return "p2r";
            default: return "";
        endcase
    endfunction

    task automatic model_good(input logic [7:0] c);
        string n;
        exp_sv++;
        exp_code = c;
        if (c == 8'hE0) m_ext = 1'b1;
        else if (c == 8'hF0) m_brk = 1'b1;
        else begin
            n = key_name(m_ext, c);
            if (n != "") begin
                if (!m_brk && !held(n) && n == "p1b") exp_b1++;
                if (!m_brk && !held(n) && n == "p2b") exp_b2++;
                m_held[n] = !m_brk;
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    // Net displacement per axis; 1 = increasing coordinate.
    function automatic logic [3:0] axis_bits(input string neg_x, input string pos_x,
                                             input string neg_y, input string pos_y);
        int dx, dy;
        dx = int'(held(pos_x)) - int'(held(neg_x));
        dy = int'(held(pos_y)) - int'(held(neg_y));
        return {dx != 0, dx > 0, dy != 0, dy > 0};
    endfunction

    function automatic logic [7:0] exp_mov();
        return {axis_bits("p1l", "p1r", "p1u", "p1d"), axis_bits("p2l", "p2r", "p2u", "p2d")};
    endfunction

    function automatic logic [7:0] act_mov();
        return {kb.p1_xmov, kb.p1_xdir, kb.p1_ymov, kb.p1_ydir,
                kb.p2_xmov, kb.p2_xdir, kb.p2_ymov, kb.p2_ydir};
    endfunction

    task automatic check_all(input string tag);
        check_eq({tag, ".mov"}, act_mov(), exp_mov());
        check_eq({tag, ".scan_valid_cnt"}, sv_cnt, exp_sv);
        check_eq({tag, ".frame_error_cnt"}, fe_cnt, exp_fe);
        check_eq({tag, ".p1_bomb_cnt"}, b1_cnt, exp_b1);
        check_eq({tag, ".p2_bomb_cnt"}, b2_cnt, exp_b2);
        check_eq({tag, ".scan_code"}, kb.scan_code, exp_code);
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clock) kb.ps2_dat = b;
        repeat (H) @(negedge clock);
        kb.ps2_clk = 1'b0;
        repeat (H) @(negedge clock);
        kb.ps2_clk = 1'b1;
    endtask

    task automatic send_raw(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                            input int nbits);
        logic [10:0] f;
        f = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
        @(negedge clock) kb.ps2_dat = 1'b1;
        repeat (4 * H) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] c, input bit bad_par, input bit bad_stop,
                             input string tag);
        send_raw(c, bad_par, bad_stop, 11);
        if (bad_par || bad_stop) begin
            exp_fe++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else begin
            model_good(c);
        end
        check_all(tag);
    endtask

    task automatic key(input bit ext, input bit brk, input logic [7:0] c, input string tag);
        if (ext) send_byte(8'hE0, 1'b0, 1'b0, {tag, ".e0"});
        if (brk) send_byte(8'hF0, 1'b0, 1'b0, {tag, ".f0"});
        send_byte(c, 1'b0, 1'b0, tag);
    endtask

    logic [8:0] keys [13] = '{9'h01D, 9'h01B, 9'h01C, 9'h023, 9'h029, 9'h05A,
                              9'h175, 9'h172, 9'h16B, 9'h174, 9'h15A, 9'h074, 9'h015};

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [8:0] k;
        bit         brk;
        kb.ps2_clk = 1'b1;
        kb.ps2_dat = 1'b1;
        reset = 1'b1;
        repeat (5) @(negedge clock);
        check_eq("reset.mov", act_mov(), 8'h00);
        check_eq("reset.scan_code", kb.scan_code, 8'h00);
        check_eq("reset.pulses", {kb.scan_valid, kb.frame_error, kb.p1_bomb, kb.p2_bomb}, 4'h0);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        check_all("post_reset");

        // Directed scenarios.
        key(1'b0, 1'b0, 8'h1D, "w_make");
        key(1'b0, 1'b1, 8'h1D, "w_break");
        key(1'b0, 1'b0, 8'h1C, "a_make");
        key(1'b0, 1'b0, 8'h23, "d_make");
        key(1'b0, 1'b1, 8'h1C, "a_break");
        key(1'b0, 1'b1, 8'h23, "d_break");
        key(1'b1, 1'b0, 8'h74, "e0_74_make");
        key(1'b1, 1'b1, 8'h74, "e0_74_break");
        key(1'b0, 1'b0, 8'h74, "bare_74");
        for (int i = 0; i < 3; i++) key(1'b0, 1'b0, 8'h29, "space_typematic");
        key(1'b0, 1'b1, 8'h29, "space_break");
        key(1'b0, 1'b0, 8'h29, "space_again");
        key(1'b0, 1'b1, 8'h29, "space_release");
        key(1'b0, 1'b0, 8'h5A, "enter_make");
        key(1'b0, 1'b1, 8'h5A, "enter_break");
        key(1'b1, 1'b0, 8'h5A, "kp_enter");
        send_byte(8'h1B, 1'b1, 1'b0, "bad_parity");
        send_byte(8'h1B, 1'b0, 1'b1, "bad_stop");
        key(1'b0, 1'b0, 8'h1B, "s_after_errors");
        send_byte(8'hF0, 1'b0, 1'b0, "brk_then_err.f0");
        send_byte(8'h1B, 1'b1, 1'b0, "brk_then_err.bad");
        send_byte(8'h1B, 1'b0, 1'b0, "brk_then_err.s");

        // Random key traffic with occasional corrupted frames.
        for (int i = 0; i < 45; i++) begin
            k   = keys[$urandom_range(0, 12)];
            brk = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 7) == 0)
                send_byte(8'($urandom_range(0, 255)), 1'b1, $urandom_range(0, 1) == 1, "rnd_bad");
            if (k[8] && brk && $urandom_range(0, 1) == 1) begin
                send_byte(8'hF0, 1'b0, 1'b0, "rnd.f0");
                send_byte(8'hE0, 1'b0, 1'b0, "rnd.e0");
                send_byte(k[7:0], 1'b0, 1'b0, "rnd.key");
            end else begin
                key(k[8], brk, k[7:0], "rnd");
            end
        end

        // Watchdog: pending E0 is dropped along with the stalled frame.
        send_byte(8'hE0, 1'b0, 1'b0, "wd.e0");
        send_raw(8'h1D, 1'b0, 1'b0, 6);
        repeat (Timeout + 10) @(negedge clock);
        m_ext = 1'b0;
        m_brk = 1'b0;
        check_all("wd.stalled");
        send_byte(8'h75, 1'b0, 1'b0, "wd.bare_75");
        key(1'b0, 1'b0, 8'h1D, "wd.recover");

        // Reset in the middle of a frame with keys held.
        key(1'b0, 1'b0, 8'h23, "rst.d_make");
        send_raw(8'h1C, 1'b0, 1'b0, 4);
        @(negedge clock) reset = 1'b1;
        repeat (2) @(negedge clock);
        check_eq("rst_mid.mov", act_mov(), 8'h00);
        check_eq("rst_mid.scan_code", kb.scan_code, 8'h00);
        @(negedge clock) reset = 1'b0;
        m_held.delete();
        m_ext = 1'b0;
        m_brk = 1'b0;
        exp_code = 8'h00;
        repeat (5) @(negedge clock);
        check_all("rst_mid.after");
        key(1'b0, 1'b0, 8'h1B, "rst.s_make");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
